eeprom_i2c_master: RTL

//   Two-wire (I2C) bus master that sequences byte-write and random-read

---
 rtl/eeprom_i2c_master.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/eeprom_i2c_master.sv
// eeprom_i2c_master
//   Sole I2C bus master for a 2048x8 serial EEPROM (8 pages of 256 bytes).
//   Runs byte-write and random-read transactions for a simple host
//   interface and holds busy through the EEPROM internal write time.
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   wr_req, rd_req    host requests (level), sampled only while idle; write wins
//   addr, wdata       byte address {page[2:0], word[7:0]} and write data
//   rdata             read data, updated at done of an error-free read
//   busy, done        transaction in progress / one-clock completion pulse
//   ack_err           a slave ACK was missing in the last transaction
//   scl, sda          bus clock (push-pull) and open-drain bus data
module eeprom_i2c_master #(
    parameter int unsigned DIV    = 50,
    parameter int unsigned T_WR   = 5000,
    parameter logic [3:0]  DEV_ID = 4'b1010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic [10:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        scl,
    inout  wire         sda
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned WW = $clog2(T_WR + 1);

    typedef enum logic [3:0] {
        IDLE, START, CTRL_W, ACK1, ADDR, ACK2, WDATA, ACK3,
        RSTART, CTRL_R, ACK4, RDATA, NACK, STOP, TWAIT, DONE
    } state_t;

    state_t        state_q;
    logic [DW-1:0] div_q;
    logic [1:0]    ph_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q, rx_q, wdata_q, rdata_q;
    logic [10:0]   addr_q;
    logic [WW-1:0] wait_q;
    logic          is_rd_q, nack_q, busy_q, done_q, ack_err_q, scl_q, sda_oe_q;
    logic          tick, sda_in;
    logic [7:0]    ctrl_w, ctrl_r;

    assign tick    = (div_q == DW'(DIV - 1));
    assign sda_in  = sda;              // a released line reads as 1 (pull-up)
    assign ctrl_w  = {DEV_ID, addr_q[10:8], 1'b0};
    assign ctrl_r  = {DEV_ID, addr_q[10:8], 1'b1};
    assign sda     = sda_oe_q ? 1'b0 : 1'bz;
    assign scl     = scl_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            ph_q      <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            rx_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            addr_q    <= '0;
            wait_q    <= '0;
            is_rd_q   <= 1'b0;
            nack_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    div_q <= '0;
                    ph_q  <= '0;
                    if (wr_req || rd_req) begin
                        is_rd_q   <= !wr_req;
                        addr_q    <= addr;
                        wdata_q   <= wdata;
                        busy_q    <= 1'b1;
                        ack_err_q <= 1'b0;
                        scl_q     <= 1'b0;      // q0 of the START slot
                        sda_oe_q  <= 1'b0;
                        state_q   <= START;
                    end
                end
                TWAIT: begin
                    if (wait_q == WW'(T_WR - 1)) state_q <= DONE;
                    else wait_q <= wait_q + 1'b1;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    if (is_rd_q && !ack_err_q) rdata_q <= rx_q;
                    state_q <= IDLE;
                end
                default: begin
                    if (!tick) begin
                        div_q <= div_q + 1'b1;
                    end else begin
                        div_q <= '0;
                        ph_q  <= ph_q + 2'd1;
                        case (ph_q)
                            2'd1: scl_q <= 1'b1;
                            2'd2: begin
                                // end of q2 (mid-high): sample, and place START/STOP edges
                                nack_q <= sda_in;
                                if (state_q == RDATA) rx_q <= {rx_q[6:0], sda_in};
                                if (state_q == START || state_q == RSTART) sda_oe_q <= 1'b1;
                                if (state_q == STOP) sda_oe_q <= 1'b0;
                            end
                            2'd3: begin
                                // slot end = next slot's q0: scl low, sda gets next bit.
                                // Defaults serve the transmit-byte states (bit counter wraps 7->0).
                                scl_q    <= 1'b0;
                                bit_q    <= bit_q + 3'd1;
                                sh_q     <= {sh_q[6:0], sh_q[7]};
                                sda_oe_q <= !sh_q[6];
                                case (state_q)
                                    START: begin
                                        state_q <= CTRL_W; sh_q <= ctrl_w;
                                        sda_oe_q <= !ctrl_w[7]; bit_q <= '0;
                                    end
                                    CTRL_W: if (bit_q == 3'd7) begin state_q <= ACK1; sda_oe_q <= 1'b0; end
                                    ADDR:   if (bit_q == 3'd7) begin state_q <= ACK2; sda_oe_q <= 1'b0; end
                                    WDATA:  if (bit_q == 3'd7) begin state_q <= ACK3; sda_oe_q <= 1'b0; end
                                    CTRL_R: if (bit_q == 3'd7) begin state_q <= ACK4; sda_oe_q <= 1'b0; end
                                    ACK1: begin
                                        if (nack_q) begin
                                            ack_err_q <= 1'b1; state_q <= STOP; sda_oe_q <= 1'b1;
                                        end else begin
                                            state_q <= ADDR; sh_q <= addr_q[7:0];
                                            sda_oe_q <= !addr_q[7]; bit_q <= '0;
                                        end
                                    end
                                    ACK2: begin
                                        if (nack_q) begin
                                            ack_err_q <= 1'b1; state_q <= STOP; sda_oe_q <= 1'b1;
                                        end else if (is_rd_q) begin
                                            state_q <= RSTART; sda_oe_q <= 1'b0;
                                        end else begin
                                            state_q <= WDATA; sh_q <= wdata_q;
                                            sda_oe_q <= !wdata_q[7]; bit_q <= '0;
                                        end
                                    end
                                    ACK3: begin
                                        if (nack_q) ack_err_q <= 1'b1;
                                        state_q <= STOP; sda_oe_q <= 1'b1;
                                    end
                                    RSTART: begin
                                        state_q <= CTRL_R; sh_q <= ctrl_r;
                                        sda_oe_q <= !ctrl_r[7]; bit_q <= '0;
                                    end
                                    ACK4: begin
                                        if (nack_q) begin
                                            ack_err_q <= 1'b1; state_q <= STOP; sda_oe_q <= 1'b1;
                                        end else begin
                                            state_q <= RDATA; sda_oe_q <= 1'b0; bit_q <= '0;
                                        end
                                    end
                                    RDATA: begin
                                        sda_oe_q <= 1'b0;
                                        if (bit_q == 3'd7) state_q <= NACK;
                                    end
                                    NACK: begin
                                        state_q <= STOP; sda_oe_q <= 1'b1;
                                    end
                                    STOP: begin
                                        scl_q    <= 1'b1;   // bus left idle
                                        sda_oe_q <= 1'b0;
                                        wait_q   <= '0;
                                        state_q  <= (!is_rd_q && !ack_err_q) ? TWAIT : DONE;
                                    end
                                    default: state_q <= IDLE;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
